// File: rtl/ram_ctrl_pkg.sv
// Shared types and default geometry for the RAM controller.
// The verify states exist only when RAM_CTRL_WRITE_VERIFY_EN is defined.
package ram_ctrl_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_ADDR_WIDTH = 5;
  localparam int DEF_DEPTH      = 32;

  typedef enum logic [2:0] {
    ST_IDLE        = 3'd0,
    ST_WRITE       = 3'd1,
    ST_READ_WAIT   = 3'd2,
    ST_READ_CAP    = 3'd3,
    ST_RESP        = 3'd4,
`ifdef RAM_CTRL_WRITE_VERIFY_EN
    ST_CLEAR       = 3'd5,
    ST_VERIFY_WAIT = 3'd6,
    ST_VERIFY_CMP  = 3'd7
`else
    ST_CLEAR       = 3'd5
`endif
  } state_e;

endpackage

// File: rtl/ram_ctrl.sv
// Host-command front end for a synchronous-read RAM: single writes, reads with a
// held response, and a full-array clear. RAM_CTRL_WRITE_VERIFY_EN adds read-back verify.
module ram_ctrl
  import ram_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DEPTH      = DEF_DEPTH
) (
  input  logic                  clk,
  input  logic                  reset,
  // Handshakes: a transfer happens on a rising edge where valid && ready.
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  input  logic                  clear_start,
  input  logic [DATA_WIDTH-1:0] clear_value,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic                  busy,
  output logic [ADDR_WIDTH-1:0] address_write,
  output logic [DATA_WIDTH-1:0] data_write,
  output logic                  write_enable,
  output logic [ADDR_WIDTH-1:0] address_read,
  input  logic [DATA_WIDTH-1:0] data_read,
`ifdef RAM_CTRL_WRITE_VERIFY_EN
  output logic                  verify_error,
`endif
  output state_e                state_dbg
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] waddr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [ADDR_WIDTH-1:0] raddr_q;
  logic [DATA_WIDTH-1:0] rdata_q;
`ifdef RAM_CTRL_WRITE_VERIFY_EN
  logic                  verr_q;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (clear_start)    state_d = ST_CLEAR;
        else if (cmd_valid) state_d = cmd_write ? ST_WRITE : ST_READ_WAIT;
      end
`ifdef RAM_CTRL_WRITE_VERIFY_EN
      ST_WRITE:       state_d = ST_VERIFY_WAIT;
      ST_VERIFY_WAIT: state_d = ST_VERIFY_CMP;
      ST_VERIFY_CMP:  state_d = ST_IDLE;
`else
      ST_WRITE:       state_d = ST_IDLE;
`endif
      ST_READ_WAIT:   state_d = ST_READ_CAP;
      ST_READ_CAP:    state_d = ST_RESP;
      ST_RESP:        if (rsp_ready) state_d = ST_IDLE;
      ST_CLEAR:       if (waddr_q == LAST_ADDR) state_d = ST_IDLE;
      default:        state_d = ST_IDLE;
    endcase
  end

  // cmd_ready is gated by reset so it reads 0 while reset is held.
  always_comb begin
    cmd_ready    = 1'b0;
    write_enable = 1'b0;
    rsp_valid    = 1'b0;
    busy         = (state_q != ST_IDLE);
    case (state_q)
      ST_IDLE:            cmd_ready = !clear_start && !reset;
      ST_WRITE, ST_CLEAR: write_enable = 1'b1;
      ST_RESP:            rsp_valid = 1'b1;
      default: ;
    endcase
  end

  // waddr_q doubles as the clear counter; wdata_q holds the latched clear value.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      waddr_q <= '0;
      wdata_q <= '0;
      raddr_q <= '0;
      rdata_q <= '0;
`ifdef RAM_CTRL_WRITE_VERIFY_EN
      verr_q  <= 1'b0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (clear_start) begin
            waddr_q <= '0;
            wdata_q <= clear_value;
          end else if (cmd_valid && cmd_write) begin
            waddr_q <= cmd_addr;
            wdata_q <= cmd_wdata;
          end else if (cmd_valid) begin
            raddr_q <= cmd_addr;
          end
        end
        ST_CLEAR:    if (waddr_q != LAST_ADDR) waddr_q <= waddr_q + 1'b1;
        ST_READ_CAP: rdata_q <= data_read;
`ifdef RAM_CTRL_WRITE_VERIFY_EN
        ST_WRITE:      raddr_q <= waddr_q;
        ST_VERIFY_CMP: if (data_read != wdata_q) verr_q <= 1'b1;
`endif
        default: ;
      endcase
    end
  end

  assign address_write = waddr_q;
  assign data_write    = wdata_q;
  assign address_read  = raddr_q;
  assign rsp_data      = rdata_q;
  assign state_dbg     = state_q;
`ifdef RAM_CTRL_WRITE_VERIFY_EN
  assign verify_error  = verr_q;
`endif

endmodule

// File: tb/tb_ram_ctrl.sv
// Randomized bench for ram_ctrl with a registered-read RAM model and an intended-contents
// reference array; with RAM_CTRL_WRITE_VERIFY_EN the RAM corrupts writes to address 0x05.
module tb_ram_ctrl;
  import ram_ctrl_pkg::*;

  localparam int DW = 8;
  localparam int AW = 5;
  localparam int DEPTH = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          cmd_valid, cmd_ready, cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic          clear_start;
  logic [DW-1:0] clear_value;
  logic          rsp_valid, rsp_ready;
  logic [DW-1:0] rsp_data;
  logic          busy;
  logic [AW-1:0] address_write, address_read;
  logic [DW-1:0] data_write, data_read;
  logic          write_enable;
  state_e        state_dbg;
`ifdef RAM_CTRL_WRITE_VERIFY_EN
  logic          verify_error;
`endif

  ram_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .clear_start(clear_start), .clear_value(clear_value),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .busy(busy),
    .address_write(address_write), .data_write(data_write), .write_enable(write_enable),
    .address_read(address_read), .data_read(data_read),
`ifdef RAM_CTRL_WRITE_VERIFY_EN
    .verify_error(verify_error),
`endif
    .state_dbg(state_dbg)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- RAM model ----------------
  logic [DW-1:0] ram_mem [DEPTH];
  initial for (int i = 0; i < DEPTH; i++) ram_mem[i] = '0;

  always @(posedge clk) begin
    if (write_enable) begin
`ifdef RAM_CTRL_WRITE_VERIFY_EN
      if (address_write == 5'h05) ram_mem[address_write] <= ~data_write;
      else                        ram_mem[address_write] <= data_write;
`else
      ram_mem[address_write] <= data_write;
`endif
    end
    data_read <= ram_mem[address_read];
  end

  // ---------------- reference model / scoreboard ----------------
  logic [DW-1:0] exp_mem [DEPTH];
  logic [DW-1:0] exp_q[$];
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready();
    for (int i = 0; i < 200 && cmd_ready !== 1'b1; i++) tick();
    check_eq("cmd_ready_wait", cmd_ready, 1);
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    wait_ready();
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = a; cmd_wdata = d;
    tick();
    cmd_valid = 1'b0;
    check_eq("wr_we_high", write_enable, 1);
    check_eq("wr_addr", address_write, a);
    check_eq("wr_data", data_write, d);
    check_eq("wr_busy", busy, 1);
    exp_mem[a] = d;
    tick();
    check_eq("wr_we_low", write_enable, 0);
`ifdef RAM_CTRL_WRITE_VERIFY_EN
    check_eq("vfy_wait_ready0", cmd_ready, 0);
    tick();
    check_eq("vfy_cmp_ready0", cmd_ready, 0);
    tick();
    check_eq("vfy_done_ready1", cmd_ready, 1);
`else
    check_eq("wr_done_ready1", cmd_ready, 1);
`endif
  endtask

  task automatic do_read(input logic [AW-1:0] a, input int hold, input logic poke_clear);
    logic [DW-1:0] exp, first;
    wait_ready();
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = a;
    exp_q.push_back(exp_mem[a]);
    tick();
    cmd_valid = 1'b0;
    check_eq("rd_addr", address_read, a);
    check_eq("rd_valid_n0", rsp_valid, 0);
    tick();
    check_eq("rd_valid_n1", rsp_valid, 0);
    tick();
    check_eq("rd_valid_n2", rsp_valid, 1);
    exp = exp_q.pop_front();
    check_eq("rd_data", rsp_data, exp);
    first = rsp_data;
    rsp_ready = 1'b0;
    for (int i = 0; i < hold; i++) begin
      clear_start = poke_clear;
      clear_value = DW'($urandom_range(0, 255));
      tick();
      check_eq("hold_valid", rsp_valid, 1);
      check_eq("hold_data", rsp_data, first);
      check_eq("hold_cmd_ready", cmd_ready, 0);
    end
    clear_start = 1'b0;
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check_eq("rsp_done_valid", rsp_valid, 0);
    check_eq("rsp_done_busy", busy, 0);
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_cmd_ready"}, cmd_ready, 0);
    check_eq({tag, "_we"}, write_enable, 0);
    check_eq({tag, "_busy"}, busy, 0);
    check_eq({tag, "_rsp_valid"}, rsp_valid, 0);
    check_eq({tag, "_rsp_data"}, rsp_data, 0);
    check_eq({tag, "_aw"}, address_write, 0);
    check_eq({tag, "_dw"}, data_write, 0);
    check_eq({tag, "_ar"}, address_read, 0);
`ifdef RAM_CTRL_WRITE_VERIFY_EN
    check_eq({tag, "_verify_error"}, verify_error, 0);
`endif
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [AW-1:0] a;
    reset = 1'b1;
    cmd_valid = 0; cmd_write = 0; cmd_addr = '0; cmd_wdata = '0;
    clear_start = 0; clear_value = '0; rsp_ready = 0;
    for (int i = 0; i < DEPTH; i++) exp_mem[i] = '0;

    // Reset pulse
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("rst");
    reset = 1'b0;
    #1;
    check_eq("rst_release_ready", cmd_ready, 1);

    // Directed write then read
    do_write(5'h1B, 8'hC5);
    do_read(5'h1B, 0, 1'b0);
    do_read(5'h1B, 5, 1'b0);

    // Clear with a simultaneous command
    clear_start = 1'b1; clear_value = 8'hA5;
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 5'h00;
    #1;
    check_eq("clr_prio_ready0", cmd_ready, 0);
    tick();
    clear_start = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      check_eq("clr_we", write_enable, 1);
      check_eq("clr_addr", address_write, i);
      check_eq("clr_data", data_write, 8'hA5);
      check_eq("clr_cmd_ready0", cmd_ready, 0);
      tick();
    end
    for (int i = 0; i < DEPTH; i++) exp_mem[i] = 8'hA5;
    check_eq("clr_end_we", write_enable, 0);
    check_eq("clr_end_ready", cmd_ready, 1);
    do_read(5'h00, 0, 1'b0);
    do_read(5'h1F, 1, 1'b0);

    // Randomized traffic, including clear requests while a response is pending
    for (int n = 0; n < 60; n++) begin
      a = AW'($urandom_range(0, DEPTH - 1));
`ifdef RAM_CTRL_WRITE_VERIFY_EN
      if (a == 5'h05) a = 5'h06;
`endif
      if ($urandom_range(0, 1) == 1) do_write(a, DW'($urandom_range(0, 255)));
      else do_read(a, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end

    // Reset in the middle of a clear
    do_write(5'h11, 8'h77);
    exp_mem[5'h10] = ram_mem[5'h10];
    clear_start = 1'b1; clear_value = 8'h5A;
    tick();
    clear_start = 1'b0;
    for (int i = 0; i < 64 && address_write !== 5'h10; i++) tick();
    check_eq("mid_clr_addr", address_write, 5'h10);
    #2;
    reset = 1'b1;
    #1;
    check_all_zero("mid_clr_rst");
    tick();
    reset = 1'b0;
    #1;
    check_eq("mid_clr_release_ready", cmd_ready, 1);
    for (int i = 0; i < 16; i++) exp_mem[i] = 8'h5A;
    do_read(5'h0F, 0, 1'b0);
    do_read(5'h10, 0, 1'b0);
    do_read(5'h11, 0, 1'b0);
    do_read(5'h00, 2, 1'b0);

`ifdef RAM_CTRL_WRITE_VERIFY_EN
    check_eq("vfy_clean_before", verify_error, 0);
    do_write(5'h05, 8'h3C);
    check_eq("vfy_error_set", verify_error, 1);
    do_write(5'h06, 8'h11);
    check_eq("vfy_error_sticky", verify_error, 1);
    reset = 1'b1;
    #1;
    check_eq("vfy_error_reset", verify_error, 0);
    tick();
    reset = 1'b0;
    #1;
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
